weight_mem_writer: RTL

- Fills the weight memory that feeds the systolic array's weight register bank.
- Accepts a byte-serial weight stream over a valid/ready handshake and packs N_ROWS_ARRAY consecutive weights into one row word.
- Issues one write per word on the weight memory write port (mem2_data / wr_addrs_mem2 / wr_mem2_ld).
- Defers each write while the array side is reading weights.

---
 rtl/sparhixcel_pkg.sv | 25 ++
 rtl/weight_lane_packer.sv | 46 ++++
 rtl/weight_mem_writer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sparhixcel_pkg.sv
// Shared definitions for the weight-memory fill path: parameter defaults,
// the writer state encoding and the stream checksum helper.
package sparhixcel_pkg;

    localparam int DEFAULT_N_ROWS_ARRAY = 16;
    localparam int DEFAULT_F_WIDTH      = 8;
    localparam int DEFAULT_ADDR_WIDTH   = 16;
    localparam int CHECKSUM_WIDTH       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } writer_state_t;

    // Running byte sum, wraps modulo 2^CHECKSUM_WIDTH.
    function automatic logic [CHECKSUM_WIDTH-1:0] checksum_add(
        input logic [CHECKSUM_WIDTH-1:0] sum,
        input logic [CHECKSUM_WIDTH-1:0] addend
    );
        checksum_add = sum + addend;
    endfunction

endpackage

// File: rtl/weight_lane_packer.sv
// Collects byte-serial weights into one N_ROWS_ARRAY-lane row word; lanes not
// reached before a clear or the session's last byte stay zero.
module weight_lane_packer
    import sparhixcel_pkg::*;
#(
    parameter int N_ROWS_ARRAY = DEFAULT_N_ROWS_ARRAY,
    parameter int F_WIDTH      = DEFAULT_F_WIDTH
)(
    input  logic                            clk_i,
    input  logic                            rd_weight_rst,
    input  logic                            i_clear,
    input  logic                            i_capture,
    input  logic [F_WIDTH-1:0]              i_data,
    input  logic                            i_last,
    output logic [N_ROWS_ARRAY*F_WIDTH-1:0] o_word,
    output logic                            o_word_done
);

    localparam int IDX_W = (N_ROWS_ARRAY > 1) ? $clog2(N_ROWS_ARRAY) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ROWS_ARRAY - 1);

    logic [N_ROWS_ARRAY*F_WIDTH-1:0] r_word;
    logic [IDX_W-1:0]                r_lane_idx;

    // Lane buffer and write index; clear takes priority over a capture.
    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            r_word     <= '0;
            r_lane_idx <= '0;
        end else if (i_clear) begin
            r_word     <= '0;
            r_lane_idx <= '0;
        end else if (i_capture) begin
            for (int k = 0; k < N_ROWS_ARRAY; k++) begin
                if (r_lane_idx == IDX_W'(k)) begin
                    r_word[k*F_WIDTH +: F_WIDTH] <= i_data;
                end
            end
            r_lane_idx <= (r_lane_idx == LAST_IDX) ? '0 : r_lane_idx + IDX_W'(1);
        end
    end

    assign o_word      = r_word;
    assign o_word_done = i_capture & ((r_lane_idx == LAST_IDX) | i_last);

endmodule

// File: rtl/weight_mem_writer.sv
// Packs a byte-serial weight stream into row words and writes them to the
// weight memory, deferring each write while the array reads weights.
// Optional build macro WEIGHT_WRITER_CHECKSUM_EN adds a per-session checksum_o.
module weight_mem_writer
    import sparhixcel_pkg::*;
#(
    parameter int N_ROWS_ARRAY = DEFAULT_N_ROWS_ARRAY,
    parameter int F_WIDTH      = DEFAULT_F_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
)(
    input  logic                            clk_i,
    input  logic                            rd_weight_rst,
    input  logic                            start_i,
    input  logic [ADDR_WIDTH-1:0]           start_addr_i,
    input  logic [F_WIDTH-1:0]              s_weight_data_i,
    input  logic                            s_weight_valid_i,
    input  logic                            s_weight_last_i,
    output logic                            s_weight_ready_o,
    input  logic                            rd_weight_ld_i,
    output logic [N_ROWS_ARRAY*F_WIDTH-1:0] mem2_data_o,
    output logic [ADDR_WIDTH-1:0]           wr_addrs_mem2_o,
    output logic                            wr_mem2_ld_o,
    output logic                            busy_o,
    output logic                            done_o,
`ifdef WEIGHT_WRITER_CHECKSUM_EN
    output logic [CHECKSUM_WIDTH-1:0]       checksum_o,
`endif
    output logic [ADDR_WIDTH-1:0]           words_written_o
);

    writer_state_t                   r_state;
    writer_state_t                   w_next_state;
    logic                            r_ready;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_word_last;
    logic [ADDR_WIDTH-1:0]           r_addr;
    logic [ADDR_WIDTH-1:0]           r_words;
    logic                            w_start;
    logic                            w_accept;
    logic                            w_word_done;
    logic                            w_wr_ld;
    logic                            w_clear;
    logic [N_ROWS_ARRAY*F_WIDTH-1:0] w_word;

    assign w_start  = (r_state == IDLE) & start_i;
    assign w_accept = r_ready & s_weight_valid_i;
    assign w_clear  = w_start | w_wr_ld;

    weight_lane_packer #(
        .N_ROWS_ARRAY (N_ROWS_ARRAY),
        .F_WIDTH      (F_WIDTH)
    ) u_packer (
        .clk_i        (clk_i),
        .rd_weight_rst(rd_weight_rst),
        .i_clear      (w_clear),
        .i_capture    (w_accept),
        .i_data       (s_weight_data_i),
        .i_last       (s_weight_last_i),
        .o_word       (w_word),
        .o_word_done  (w_word_done)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; the strobe is the WRITE state qualified by the array's read
    // window so a deferred word issues in the first free cycle.
    always_comb begin
        w_next_state = r_state;
        w_wr_ld      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) w_next_state = FILL;
                else         w_next_state = IDLE;
            end
            FILL: begin
                if (w_word_done) w_next_state = WRITE;
                else             w_next_state = FILL;
            end
            WRITE: begin
                if (!rd_weight_ld_i) begin
                    w_wr_ld      = 1'b1;
                    w_next_state = r_word_last ? DONE : FILL;
                end else begin
                    w_next_state = WRITE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= (w_next_state == FILL);
            r_busy  <= (w_next_state != IDLE);
            r_done  <= (w_next_state == DONE);
        end
    end

    // Address pointer, word counter and the last-word marker.
    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            r_addr      <= '0;
            r_words     <= '0;
            r_word_last <= 1'b0;
        end else if (w_start) begin
            r_addr      <= start_addr_i;
            r_words     <= '0;
            r_word_last <= 1'b0;
        end else begin
            if (w_wr_ld) begin
                r_addr  <= r_addr + ADDR_WIDTH'(1);
                r_words <= r_words + ADDR_WIDTH'(1);
            end
            if (w_word_done) begin
                r_word_last <= s_weight_last_i;
            end
        end
    end

`ifdef WEIGHT_WRITER_CHECKSUM_EN
    logic [CHECKSUM_WIDTH-1:0] r_checksum;

    // Unsigned byte sum over the session.
    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= checksum_add(r_checksum, CHECKSUM_WIDTH'(s_weight_data_i));
        end
    end

    assign checksum_o = r_checksum;
`endif

    assign s_weight_ready_o = r_ready;
    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign mem2_data_o      = w_word;
    assign wr_addrs_mem2_o  = r_addr;
    assign wr_mem2_ld_o     = w_wr_ld;
    assign words_written_o  = r_words;

endmodule
